// File: rtl/alu_agent_pkg.sv
// Shared types and constants for the ALU responder slice.
// Optional DIV datapath is enabled by defining ALU_RESPONDER_DIV_EN.
package alu_agent_pkg;

   typedef enum logic [2:0] {
      ADD = 3'd0,
      SUB = 3'd1,
      AND = 3'd2,
      XOR = 3'd3,
      MUL = 3'd4,
      DIV = 3'd5
   } op_type_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int RESULT_W   = 16;
   localparam int MUL_CYCLES = 16;

   // Single-cycle operations; anything not handled here (including DIV when
   // the divider is not built) returns zero.
   function automatic logic [RESULT_W-1:0] simple_op(input op_type_t op,
                                                     input logic [RESULT_W-1:0] a,
                                                     input logic [RESULT_W-1:0] b);
      logic [RESULT_W-1:0] r;
      case (op)
         ADD:     r = a + b;
         SUB:     r = a - b;
         AND:     r = a & b;
         XOR:     r = a ^ b;
         default: r = {RESULT_W{1'b0}};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_responder_if.sv
// Request/response bundle between the ALU stimulus side and the responder.
interface alu_responder_if #(parameter int ID_W = 32);
   import alu_agent_pkg::*;

   logic [RESULT_W-1:0] val1;
   logic [RESULT_W-1:0] val2;
   op_type_t            mode;
   logic                valid_i;
   logic [ID_W-1:0]     txn_id;
   logic [RESULT_W-1:0] result;
   logic                valid_o;
   logic [ID_W-1:0]     txn_id_o;
   logic                busy;
   logic                overflow;

   modport master (
      output val1, val2, mode, valid_i, txn_id,
      input  result, valid_o, txn_id_o, busy, overflow
   );

   modport slave (
      input  val1, val2, mode, valid_i, txn_id,
      output result, valid_o, txn_id_o, busy, overflow
   );

endinterface

// File: rtl/alu_req_fifo.sv
// Request queue: DEPTH entries (power of two), extra count bit separates
// full from empty. A push while full is accepted only with a same-cycle pop.
module alu_req_fifo #(
   parameter int  DEPTH = 4,
   parameter int  WIDTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full      = (count_q == (AW+1)'(DEPTH));
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign rdata     = mem_q[rd_ptr_q];
   assign pop_ok_s  = pop && !empty;
   assign push_ok_s = push && (!full || pop_ok_s);

   // Next pointer and occupancy values.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; written at the tail on an accepted push.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push_ok_s) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/alu_responder.sv
// ALU responder: queues requests, executes them in order (single-cycle ops,
// 16-cycle shift-add multiplier) and returns one valid_o pulse per request.
// Define ALU_RESPONDER_DIV_EN to build the 16-cycle restoring divider.
module alu_responder
   import alu_agent_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int ID_W  = 32
) (
   input  logic           clk,
   input  logic           rst,
   alu_responder_if.slave bus
);

   localparam int OP_W  = $bits(op_type_t);
   localparam int REQ_W = 2*RESULT_W + OP_W + ID_W;
   localparam int AW    = $clog2(DEPTH);
   localparam logic [3:0] LAST_CNT = 4'(MUL_CYCLES - 1);

   logic [REQ_W-1:0]    fifo_wdata_s;
   logic [REQ_W-1:0]    fifo_rdata_s;
   logic                fifo_full_s;
   logic                fifo_empty_s;
   logic [AW:0]         fifo_count_s;
   logic                pop_s;

   logic [RESULT_W-1:0] rd_v1_s;
   logic [RESULT_W-1:0] rd_v2_s;
   op_type_t            rd_op_s;
   logic [ID_W-1:0]     rd_id_s;

   state_t              state_q, state_d;
   op_type_t            op_q, op_d;
   logic [RESULT_W-1:0] a_q, a_d;
   logic [RESULT_W-1:0] b_q, b_d;
   logic [RESULT_W-1:0] acc_q, acc_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [RESULT_W-1:0] res_q, res_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [RESULT_W-1:0] out_res_q, out_res_d;
   logic [ID_W-1:0]     out_id_q, out_id_d;
   logic                valid_q, valid_d;
   logic                overflow_q, overflow_d;

`ifdef ALU_RESPONDER_DIV_EN
   logic [RESULT_W:0]   rem_sh_s;
`endif

   assign fifo_wdata_s = {bus.val1, bus.val2, bus.mode, bus.txn_id};
   assign rd_v1_s      = fifo_rdata_s[REQ_W-1 -: RESULT_W];
   assign rd_v2_s      = fifo_rdata_s[REQ_W-RESULT_W-1 -: RESULT_W];
   assign rd_op_s      = op_type_t'(fifo_rdata_s[ID_W+OP_W-1 -: OP_W]);
   assign rd_id_s      = fifo_rdata_s[ID_W-1:0];
   assign pop_s        = (state_q == ST_IDLE) && !fifo_empty_s;

   alu_req_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (REQ_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (bus.valid_i),
      .pop   (pop_s),
      .wdata (fifo_wdata_s),
      .rdata (fifo_rdata_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .count (fifo_count_s)
   );

   assign bus.result   = out_res_q;
   assign bus.txn_id_o = out_id_q;
   assign bus.valid_o  = valid_q;
   assign bus.overflow = overflow_q;
   assign bus.busy     = (fifo_count_s != '0) || (state_q != ST_IDLE);

   // Sticky drop flag: push while full with no pop in the same cycle.
   always_comb begin
      if (bus.valid_i && fifo_full_s && !pop_s) begin
         overflow_d = 1'b1;
      end else begin
         overflow_d = overflow_q;
      end
   end

   // Next-state, datapath and output-register values for the executor FSM.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      res_d     = res_q;
      id_d      = id_q;
      out_res_d = out_res_q;
      out_id_d  = out_id_q;
      valid_d   = 1'b0;
`ifdef ALU_RESPONDER_DIV_EN
      rem_sh_s  = {acc_q, b_q[RESULT_W-1]};
`endif
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty_s) begin
               op_d = rd_op_s;
               id_d = rd_id_s;
               case (rd_op_s)
                  MUL: begin
                     a_d     = rd_v1_s;
                     b_d     = rd_v2_s;
                     acc_d   = {RESULT_W{1'b0}};
                     cnt_d   = 4'd0;
                     state_d = ST_EXEC;
                  end
`ifdef ALU_RESPONDER_DIV_EN
                  DIV: begin
                     if (rd_v2_s == {RESULT_W{1'b0}}) begin
                        res_d   = {RESULT_W{1'b1}};
                        state_d = ST_DONE;
                     end else begin
                        a_d     = rd_v2_s;
                        b_d     = rd_v1_s;
                        acc_d   = {RESULT_W{1'b0}};
                        cnt_d   = 4'd0;
                        state_d = ST_EXEC;
                     end
                  end
`endif
                  default: begin
                     res_d   = simple_op(rd_op_s, rd_v1_s, rd_v2_s);
                     state_d = ST_DONE;
                  end
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            cnt_d = cnt_q + 4'd1;
            case (op_q)
               MUL: begin
                  // Shift-add, multiplier LSB first; product kept modulo 2^16.
                  if (b_q[0]) begin
                     acc_d = acc_q + a_q;
                  end else begin
                     acc_d = acc_q;
                  end
                  a_d = {a_q[RESULT_W-2:0], 1'b0};
                  b_d = {1'b0, b_q[RESULT_W-1:1]};
                  if (cnt_q == LAST_CNT) begin
                     res_d   = acc_d;
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_EXEC;
                  end
               end
`ifdef ALU_RESPONDER_DIV_EN
               DIV: begin
                  // Restoring division: dividend shifts out of b_q MSB first,
                  // quotient bits shift into b_q from the bottom.
                  if (rem_sh_s >= {1'b0, a_q}) begin
                     acc_d = RESULT_W'(rem_sh_s - {1'b0, a_q});
                     b_d   = {b_q[RESULT_W-2:0], 1'b1};
                  end else begin
                     acc_d = rem_sh_s[RESULT_W-1:0];
                     b_d   = {b_q[RESULT_W-2:0], 1'b0};
                  end
                  if (cnt_q == LAST_CNT) begin
                     res_d   = b_d;
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_EXEC;
                  end
               end
`endif
               default: begin
                  res_d   = {RESULT_W{1'b0}};
                  state_d = ST_DONE;
               end
            endcase
         end
         ST_DONE: begin
            valid_d   = 1'b1;
            out_res_d = res_q;
            out_id_d  = id_q;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM, datapath and registered output state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         op_q       <= ADD;
         a_q        <= '0;
         b_q        <= '0;
         acc_q      <= '0;
         cnt_q      <= 4'd0;
         res_q      <= '0;
         id_q       <= '0;
         out_res_q  <= '0;
         out_id_q   <= '0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         res_q      <= res_d;
         id_q       <= id_d;
         out_res_q  <= out_res_d;
         out_id_q   <= out_id_d;
         valid_q    <= valid_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: doc/alu_responder.md
Name: alu_responder

Overview:
- DUT-side responder for the ALU stimulus interface. Accepts one-cycle valid_i pulses carrying val1/val2/mode/txn_id and buffers them in a small queue.
- Executes the operations one at a time: single-cycle logic/arith ops and an iterative multiplier. Returns result with a one-cycle valid_o pulse and the echoed transaction id.
- Sits between the driver BFM outputs and the monitor/response path, so get_response-style matching on valid_o plus txn_id works.

Parameters:
- DEPTH, 4, input queue entries (power of 2, >=2)
- ID_W, 32, transaction id width

Ports:
- clk  input  1  single clock; all state changes on posedge
- rst  input  1  asynchronous, active-high reset
- val1  input  16  operand A
- val2  input  16  operand B
- mode  input  op_type_t  operation select
- valid_i  input  1  one-cycle request strobe; there is no backpressure
- txn_id  input  ID_W  request tag
- result  output  16  operation result; the type is shortint unsigned
- valid_o  output  1  one-cycle result strobe
- txn_id_o  output  ID_W  tag echoed with result
- busy  output  1  high when the queue is non-empty or the FSM is not IDLE
- overflow  output  1  sticky; a request was dropped

Behaviour:
- Reset (async, rst=1): result=0, valid_o=0, txn_id_o=0, busy=0, overflow=0, queue empty, FSM=IDLE. Reset mid-operation discards the queue and any in-flight op; no valid_o follows.

Queue:
- On a posedge with valid_i=1, {val1,val2,mode,txn_id} is pushed.
- Push when full and no pop in the same cycle: request dropped, overflow<=1 until reset.
- Push when full with a simultaneous pop: accepted.
- Pointers wrap modulo DEPTH. An extra count bit distinguishes full from empty.

FSM states: IDLE, EXEC, DONE.
- IDLE, queue non-empty: pop head into op registers.
  - ADD/SUB/AND/XOR: result computed and registered this cycle; go to DONE.
  - MUL: load multiplicand/multiplier/accumulator; bit counter=0; go to EXEC.
- EXEC (MUL, shift-add, 1 bit per cycle, LSB first): exactly 16 cycles. On counter==15, register the low 16 bits of the product; go to DONE.
- DONE: valid_o=1 for exactly this cycle, with result and txn_id_o stable. Next state is IDLE. A pop can occur in the following cycle, so back-to-back results are spaced by at least 2 cycles.

Latency with an empty queue, request sampled at edge N:
- Pop at edge N+1; valid_o high after edge N+2 for simple ops.
- MUL: valid_o high after edge N+18.

Output timing:
- result/txn_id_o hold their last values outside valid_o.
- valid_o is deasserted by the edge after DONE, so it is stable across the intervening negedge sample point.

Arithmetic:
- All ops modulo 2^16. ADD wraps, SUB wraps (0-1=0xFFFF). MUL is truncated to the low 16 bits.
- Unknown mode encodings return 0 with a normal valid_o.
- Ordering: strict FIFO; results are returned in request order.

Optional Feature:
- Macro ALU_RESPONDER_DIV_EN.
- Defined:
  - Adds op DIV: restoring division, 16 EXEC cycles, quotient returned.
  - Divide by zero returns 0xFFFF without iterating (DONE the cycle after pop).
- Undefined:
  - DIV encoding is treated as unknown: returns 0, simple-op latency.
  - No divider logic is synthesized.

Decomposition:
- Shared package alu_agent_pkg holds:
  - op_type_t (enum: ADD=0, SUB=1, AND=2, XOR=3, MUL=4, DIV=5)
  - RESULT_W=16
  - MUL_CYCLES=16
- One sub-module, alu_req_fifo: parameterized DEPTH/width queue with push/pop/full/empty/count.
- FSM and datapath live in alu_responder.

Test Plan:
- ADD val1=0xFFFF, val2=0x0002, txn_id=7 → one valid_o pulse, 2 cycles after acceptance; result=0x0001, txn_id_o=7.
- MUL 0x0100*0x0100, then ADD 3+4, back-to-back → MUL result 0x0000 (truncated) at N+18, then ADD result 0x0007; ids in order.
- Five MUL requests on consecutive cycles, DEPTH=4 → the first pops at N+1 and the rest fill the queue with no drop; a sixth request while the queue is full with no pop → overflow=1; exactly 5 valid_o pulses.
- Assert rst during the EXEC of a MUL with 2 entries queued → outputs 0 immediately, busy=0, no valid_o afterwards; the next ADD 1+1 returns 0x0002.
- SUB 0x0000-0x0001 → 0xFFFF; AND 0xF0F0&0x0FF0 → 0x00F0; mode=7 → 0x0000, valid_o still pulses.
- With ALU_RESPONDER_DIV_EN: DIV 100/7 → 0x000E after 16 EXEC cycles; DIV x/0 → 0xFFFF at simple-op latency. Without the macro: DIV returns 0x0000.
